tdc_int_sched: RTL and testbench

//  Round-robin scheduler sharing one pipelined thermometer-to-binary interpolator
//  (popcount pipeline: INT[15:0]/cal_en in, int_data[3:0] out) between N_CH TDC hit

---
 rtl/tdc_int_sched.sv | 183 ++++++++++++++++++
 tb/tb_tdc_int_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_int_sched.sv
// Round-robin scheduler sharing one pipelined thermometer-to-binary interpolator between
// TDC hit channels. Optional feature macro: TDC_ZERO_CHK_EN (flag all-zero thermometer words).
module tdc_int_sched #(
    parameter int N_CH       = 4,
    parameter int CW         = 12,
    parameter int PIPE_LAT   = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         hit_vld,
    input  logic [16*N_CH-1:0]      hit_int,
    input  logic [CW*N_CH-1:0]      hit_coarse,
    output logic [N_CH-1:0]         hit_rdy,
    output logic                    cal_en,
    output logic [15:0]             cal_int,
    input  logic [3:0]              int_data,
    output logic                    res_vld,
    input  logic                    res_rdy,
    output logic [$clog2(N_CH)-1:0] res_ch,
    output logic [CW-1:0]           res_coarse,
    output logic [3:0]              res_fine,
    output logic                    res_err,
    output logic                    busy
);
    localparam int CHW = $clog2(N_CH);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CRW = $clog2(FIFO_DEPTH + 1);

    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] sel_ch;
    logic [CHW-1:0] cand;
    logic           found;
    logic [CRW-1:0] credit;
    logic           transfer;
    logic           pop;
    logic           push;
    logic [15:0]    sel_int;
    logic [CW-1:0]  sel_coarse;
    logic           sel_err;

    always_comb begin
        found  = 1'b0;
        sel_ch = '0;
        cand   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand = CHW'((32'(rr_ptr) + k) % N_CH);
            if (!found && hit_vld[cand]) begin
                found  = 1'b1;
                sel_ch = cand;
            end
        end
    end

    assign transfer   = found && (credit != '0);
    assign sel_int    = hit_int[16*sel_ch +: 16];
    assign sel_coarse = hit_coarse[CW*sel_ch +: CW];

    always_comb begin
        hit_rdy = '0;
        if (transfer) begin
            hit_rdy[sel_ch] = 1'b1;
        end
    end

`ifdef TDC_ZERO_CHK_EN
    assign sel_err = (sel_int == '0);
`else
    assign sel_err = 1'b0;
`endif

    // Credits bound in-flight plus buffered samples, so the FIFO never needs a full check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            credit  <= CRW'(FIFO_DEPTH);
            cal_int <= '0;
        end else begin
            if (transfer) begin
                rr_ptr  <= (sel_ch == CHW'(N_CH - 1)) ? '0 : sel_ch + 1'b1;
                cal_int <= sel_int;
            end
            if (transfer && !pop) begin
                credit <= credit - 1'b1;
            end else if (!transfer && pop) begin
                credit <= credit + 1'b1;
            end
        end
    end

    // Stage 0 travels with cal_en; stage PIPE_LAT lines up with int_data
    logic [PIPE_LAT:0] tag_vld;
    logic [CHW-1:0]    tag_ch     [PIPE_LAT+1];
    logic [CW-1:0]     tag_coarse [PIPE_LAT+1];
    logic              tag_err    [PIPE_LAT+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld <= '0;
        end else begin
            tag_vld <= {tag_vld[PIPE_LAT-1:0], transfer};
        end
    end

    always_ff @(posedge clk) begin
        tag_ch[0]     <= sel_ch;
        tag_coarse[0] <= sel_coarse;
        tag_err[0]    <= sel_err;
        for (int unsigned s = 1; s <= PIPE_LAT; s++) begin
            tag_ch[s]     <= tag_ch[s-1];
            tag_coarse[s] <= tag_coarse[s-1];
            tag_err[s]    <= tag_err[s-1];
        end
    end

    assign cal_en = tag_vld[0];
    assign push   = tag_vld[PIPE_LAT];

    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic [PW-1:0]   rd_idx;
    logic            empty;
    logic [3:0]      push_fine;
    logic [CHW-1:0]  mem_ch     [FIFO_DEPTH];
    logic [CW-1:0]   mem_coarse [FIFO_DEPTH];
    logic [3:0]      mem_fine   [FIFO_DEPTH];
    logic            mem_err    [FIFO_DEPTH];
    logic [CHW-1:0]  last_ch;
    logic [CW-1:0]   last_coarse;
    logic [3:0]      last_fine;
    logic            last_err;

    assign empty     = (wr_ptr == rd_ptr);
    assign rd_idx    = rd_ptr[PW-1:0];
    assign res_vld   = !empty;
    assign pop       = res_vld && res_rdy;
    assign push_fine = tag_err[PIPE_LAT] ? 4'h0 : int_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ch[wr_ptr[PW-1:0]]     <= tag_ch[PIPE_LAT];
            mem_coarse[wr_ptr[PW-1:0]] <= tag_coarse[PIPE_LAT];
            mem_fine[wr_ptr[PW-1:0]]   <= push_fine;
            mem_err[wr_ptr[PW-1:0]]    <= tag_err[PIPE_LAT];
        end
    end

    // Last popped entry keeps res_* stable while the FIFO is empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_ch     <= '0;
            last_coarse <= '0;
            last_fine   <= '0;
            last_err    <= 1'b0;
        end else if (pop) begin
            last_ch     <= mem_ch[rd_idx];
            last_coarse <= mem_coarse[rd_idx];
            last_fine   <= mem_fine[rd_idx];
            last_err    <= mem_err[rd_idx];
        end
    end

    assign res_ch     = empty ? last_ch     : mem_ch[rd_idx];
    assign res_coarse = empty ? last_coarse : mem_coarse[rd_idx];
    assign res_fine   = empty ? last_fine   : mem_fine[rd_idx];
    assign res_err    = empty ? last_err    : mem_err[rd_idx];
    assign busy       = (|tag_vld) || res_vld;

endmodule

// File: tb/tb_tdc_int_sched.sv
// Randomized bench for tdc_int_sched: emulates the popcount interpolator pipeline and
// checks every cycle against a queue-based reference model.
module tb_tdc_int_sched;
    localparam int N_CH       = 4;
    localparam int CW         = 12;
    localparam int PIPE_LAT   = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int CHW        = $clog2(N_CH);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_CH-1:0]      hit_vld;
    logic [16*N_CH-1:0]   hit_int;
    logic [CW*N_CH-1:0]   hit_coarse;
    logic [N_CH-1:0]      hit_rdy;
    logic                 cal_en;
    logic [15:0]          cal_int;
    logic [3:0]           int_data;
    logic                 res_vld;
    logic                 res_rdy;
    logic [CHW-1:0]       res_ch;
    logic [CW-1:0]        res_coarse;
    logic [3:0]           res_fine;
    logic                 res_err;
    logic                 busy;

    always #5 clk = ~clk;

    tdc_int_sched #(
        .N_CH(N_CH), .CW(CW), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hit_vld(hit_vld), .hit_int(hit_int),
        .hit_coarse(hit_coarse), .hit_rdy(hit_rdy), .cal_en(cal_en), .cal_int(cal_int),
        .int_data(int_data), .res_vld(res_vld), .res_rdy(res_rdy), .res_ch(res_ch),
        .res_coarse(res_coarse), .res_fine(res_fine), .res_err(res_err), .busy(busy)
    );

    typedef struct { int ch; int coarse; int fine; int err; int at; } ent_t;

    ent_t        pend[$];
    ent_t        fifo[$];
    ent_t        last;
    int          m_ptr;
    int          m_credit;
    bit          m_cal_en;
    logic [15:0] m_cal_int;

    bit          s_vld    [N_CH];
    logic [15:0] s_int    [N_CH];
    logic [CW-1:0] s_coarse [N_CH];

    bit          hist_en  [64];
    logic [15:0] hist_int [64];

    int n;
    int n_pass;
    int n_total;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    endtask

    function automatic logic [15:0] therm(input int k);
        logic [16:0] w;
        w = (17'd1 << k) - 17'd1;
        return w[15:0];
    endfunction

    function automatic logic [15:0] rand_word();
        if ($urandom_range(0, 9) == 0) return 16'($urandom);
        return therm(int'($urandom_range(0, 16)));
    endfunction

    // Expected result: fine code = number of ones minus one, modulo 16
    function automatic ent_t make_ent(input int ch, input logic [15:0] w, input logic [CW-1:0] c);
        ent_t e;
        e.ch     = ch;
        e.coarse = int'(c);
        e.fine   = ($countones(w) + 15) % 16;
        e.err    = 0;
`ifdef TDC_ZERO_CHK_EN
        if (w == 16'h0000) begin
            e.fine = 0;
            e.err  = 1;
        end
`endif
        e.at = 0;
        return e;
    endfunction

    task automatic model_reset();
        pend.delete();
        fifo.delete();
        last      = '{default: 0};
        m_ptr     = 0;
        m_credit  = FIFO_DEPTH;
        m_cal_en  = 1'b0;
        m_cal_int = '0;
    endtask

    task automatic load(input int ch, input logic [15:0] w, input logic [CW-1:0] c);
        s_vld[ch]    = 1'b1;
        s_int[ch]    = w;
        s_coarse[ch] = c;
    endtask

    // One clock cycle: entered and left just after a rising edge
    task automatic cycle(input bit rst_now, input int new_pct, input int rdy_pct);
        int          g;
        int          c;
        int          lag;
        bit          popd;
        ent_t        hd;
        ent_t        e;
        logic [N_CH-1:0] exp_rdy;

        hist_en[n % 64]  = cal_en;
        hist_int[n % 64] = cal_int;
        lag = (n - PIPE_LAT) % 64;
        if (n >= PIPE_LAT && hist_en[lag]) int_data = 4'($countones(hist_int[lag]) - 1);
        else int_data = 4'($urandom);

        for (int i = 0; i < N_CH; i++) begin
            if (!s_vld[i] && !rst_now && int'($urandom_range(0, 99)) < new_pct)
                load(i, rand_word(), CW'($urandom));
            hit_vld[i]            = s_vld[i] && !rst_now;
            hit_int[16*i +: 16]   = s_int[i];
            hit_coarse[CW*i +: CW] = s_coarse[i];
        end
        res_rdy = (int'($urandom_range(0, 99)) < rdy_pct);
        rst_n   = !rst_now;
        #1;

        g = -1;
        if (m_credit > 0 && !rst_now) begin
            for (int k = 0; k < N_CH; k++) begin
                c = (m_ptr + k) % N_CH;
                if (g < 0 && s_vld[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        hd = (fifo.size() > 0) ? fifo[0] : last;

        chk("hit_rdy", 32'(hit_rdy), 32'(exp_rdy));
        chk("cal_en", 32'(cal_en), 32'(m_cal_en));
        chk("cal_int", 32'(cal_int), 32'(m_cal_int));
        chk("res_vld", 32'(res_vld), 32'(fifo.size() > 0));
        chk("res_ch", 32'(res_ch), 32'(hd.ch));
        chk("res_coarse", 32'(res_coarse), 32'(hd.coarse));
        chk("res_fine", 32'(res_fine), 32'(hd.fine));
        chk("res_err", 32'(res_err), 32'(hd.err));
        chk("busy", 32'(busy), 32'(pend.size() > 0 || fifo.size() > 0));

        if (rst_now) begin
            model_reset();
        end else begin
            popd = (fifo.size() > 0) && res_rdy;
            if (popd) last = fifo.pop_front();
            while (pend.size() > 0 && pend[0].at == n + 1) fifo.push_back(pend.pop_front());
            if (g >= 0) begin
                e    = make_ent(g, s_int[g], s_coarse[g]);
                e.at = n + PIPE_LAT + 2;
                pend.push_back(e);
                s_vld[g]  = 1'b0;
                m_ptr     = (g + 1) % N_CH;
                m_cal_en  = 1'b1;
                m_cal_int = s_int[g];
            end else begin
                m_cal_en = 1'b0;
            end
            m_credit = m_credit + int'(popd) - int'(g >= 0);
        end

        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) cycle(1'b0, 0, 100);
    endtask

    initial begin
        int cnt;
        rst_n      = 1'b0;
        hit_vld    = '0;
        hit_int    = '0;
        hit_coarse = '0;
        res_rdy    = 1'b0;
        int_data   = '0;
        n          = 0;
        n_pass     = 0;
        n_total    = 0;
        for (int i = 0; i < N_CH; i++) begin
            s_vld[i]    = 1'b0;
            s_int[i]    = '0;
            s_coarse[i] = '0;
        end
        for (int i = 0; i < 64; i++) begin
            hist_en[i]  = 1'b0;
            hist_int[i] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;
        cycle(1'b1, 0, 100);
        cycle(1'b1, 0, 100);

        // Single hit on channel 2
        load(2, 16'h00FF, 12'h123);
        drain();

        // All channels continuously requesting from pointer 0
        cycle(1'b1, 0, 100);
        for (int i = 0; i < N_CH; i++) load(i, rand_word(), CW'($urandom));
        for (int i = 0; i < 16; i++) cycle(1'b0, 100, 100);
        drain();

        // Consumer stalled: credits cap issues at FIFO_DEPTH
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 100, 0);
            cnt += int'(cal_en);
        end
        chk("stall_issues", 32'(cnt), 32'(FIFO_DEPTH));
        cycle(1'b0, 0, 100);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0);
        drain();

        // Reset with three samples in flight
        load(0, rand_word(), CW'($urandom));
        load(1, rand_word(), CW'($urandom));
        load(2, rand_word(), CW'($urandom));
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 100);
        cycle(1'b1, 0, 100);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 100);

        // All-zero and all-one thermometer words
        load(0, 16'h0000, 12'h0AA);
        load(1, 16'hFFFF, 12'h0BB);
        drain();

        for (int i = 0; i < 500; i++)
            cycle($urandom_range(0, 199) == 0, 35, 60);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
